mrd_rdx_gather: RTL and testbench

Input gather stage that sits directly upstream of the mixed-radix butterflies (radix 2/3/4/5).
- Accepts one complex sample per cycle over a valid/ready handshake.
- Assembles N = 2..5 samples into the 5-lane parallel vector those butterflies consume.
- Computes the vector's block-floating-point headroom (margin) and carries the block exponent alongside the data.

---
 rtl/mrd_rdx_gather_pkg.sv | 39 +++
 rtl/mrd_rdx_gather_if.sv | 29 ++
 rtl/mrd_rdx_gather_margin.sv | 29 ++
 rtl/mrd_rdx_gather.sv | 138 +++++++++++++
 tb/tb_mrd_rdx_gather.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mrd_rdx_gather_pkg.sv
// Shared types, constants and helpers for the mixed-radix gather stage.
package mrd_pkg;

  localparam int WD    = 18;
  localparam int NLANE = 5;

  localparam logic [2:0] RDX2 = 3'd2;
  localparam logic [2:0] RDX3 = 3'd3;
  localparam logic [2:0] RDX4 = 3'd4;
  localparam logic [2:0] RDX5 = 3'd5;

  typedef struct packed {
    logic signed [WD-1:0] re;
    logic signed [WD-1:0] im;
  } cplx_t;

  // Redundant sign bits below the MSB, saturated at 3.
  function automatic logic [1:0] headroom(logic [WD-1:0] x);
    logic [1:0] h;
    h = 2'd0;
    if (x[WD-2] == x[WD-1]) begin
      h = 2'd1;
      if (x[WD-3] == x[WD-1]) begin
        h = 2'd2;
        if (x[WD-4] == x[WD-1]) h = 2'd3;
      end
    end
    return h;
  endfunction

  // Unsupported radix codes fall back to radix 4.
  function automatic logic [2:0] map_radix(logic [2:0] sel);
    case (sel)
      RDX2, RDX3, RDX4, RDX5: return sel;
      default:                return RDX4;
    endcase
  endfunction

endpackage

// File: rtl/mrd_rdx_gather_if.sv
// Sample-in / vector-out handshake bundle of the gather stage.
interface mrd_rdx_gather_if #(parameter int WD = mrd_pkg::WD);
  import mrd_pkg::*;

  logic [2:0]                  radix_sel;
  logic [3:0]                  exp_in;
  logic                        in_val;
  logic                        in_ready;
  logic signed [WD-1:0]        din_real;
  logic signed [WD-1:0]        din_imag;
  logic                        out_val;
  logic                        out_ready;
  logic [NLANE-1:0][WD-1:0]    dout_real;
  logic [NLANE-1:0][WD-1:0]    dout_imag;
  logic [2:0]                  radix_out;
  logic [1:0]                  margin_out;
  logic [3:0]                  exp_out;

  modport slave (
    input  radix_sel, exp_in, in_val, din_real, din_imag, out_ready,
    output in_ready, out_val, dout_real, dout_imag, radix_out, margin_out, exp_out
  );

  modport master (
    output radix_sel, exp_in, in_val, din_real, din_imag, out_ready,
    input  in_ready, out_val, dout_real, dout_imag, radix_out, margin_out, exp_out
  );

endinterface

// File: rtl/mrd_rdx_gather_margin.sv
// Running block-floating-point margin: min headroom over all accepted components.
module mrd_gather_margin
  import mrd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       acc,
  input  logic       seed,
  input  cplx_t      din,
  output logic [1:0] margin_nxt
);

  logic [1:0] margin_q;
  logic [1:0] h_re, h_im, h_s;

  always_comb begin
    h_re       = headroom(din.re);
    h_im       = headroom(din.im);
    h_s        = (h_re < h_im) ? h_re : h_im;
    margin_nxt = margin_q;
    if (acc) margin_nxt = seed ? h_s : ((h_s < margin_q) ? h_s : margin_q);
  end

  always_ff @(posedge clk) begin
    if (rst) margin_q <= 2'd3;
    else     margin_q <= margin_nxt;
  end

endmodule

// File: rtl/mrd_rdx_gather.sv
// Gathers 2..5 complex samples into a 5-lane vector with margin and block exponent.
// Optional MRD_GATHER_PRESCALE_EN: halve zero-margin vectors at transfer and bump the exponent.
module mrd_rdx_gather
  import mrd_pkg::*;
#(
  parameter int WD = mrd_pkg::WD
) (
  input  logic            clk,
  input  logic            rst,
  mrd_rdx_gather_if.slave bus
);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               k_q, n_q;
  logic [3:0]               exp_q;
  logic [NLANE-1:0][WD-1:0] lre_q, lim_q, lre_d, lim_d;
  logic [NLANE-1:0][WD-1:0] ore_d, oim_d;
  logic [1:0]               margin_nxt, margin_o;
  logic [3:0]               exp_o;
  logic                     acc, first, last, slot_free, xfer;

`ifdef MRD_GATHER_PRESCALE_EN
  function automatic logic [WD-1:0] half_round(logic [WD-1:0] x);
    logic signed [WD:0] s;
    s = ($signed({x[WD-1], x}) + $signed((WD+1)'(1))) >>> 1;
    if (s > $signed({2'b00, {(WD-1){1'b1}}}))      return {1'b0, {(WD-1){1'b1}}};
    else if (s < $signed({2'b11, {(WD-1){1'b0}}})) return {1'b1, {(WD-1){1'b0}}};
    else                                           return s[WD-1:0];
  endfunction
`endif

  assign bus.in_ready = (state_q == COLLECT);
  assign acc          = bus.in_val && bus.in_ready;
  assign first        = (k_q == 3'd0);
  assign last         = (k_q == 3'(n_q - 3'd1));
  assign slot_free    = !bus.out_val || bus.out_ready;
  // The last sample bypasses FULL when the slot is free, so streaming has no bubble.
  assign xfer         = slot_free && ((state_q == FULL) || (acc && last));

  mrd_gather_margin u_margin (
    .clk        (clk),
    .rst        (rst),
    .acc        (acc),
    .seed       (first),
    .din        ('{re: bus.din_real, im: bus.din_imag}),
    .margin_nxt (margin_nxt)
  );

  // NOTE: every variable driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (acc && last && !slot_free) state_d = FULL;
      FULL:    if (slot_free)                 state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    lre_d = lre_q;
    lim_d = lim_q;
    if (acc) begin
      lre_d[k_q] = bus.din_real;
      lim_d[k_q] = bus.din_imag;
    end
  end

  always_comb begin
    ore_d    = '0;
    oim_d    = '0;
    margin_o = margin_nxt;
    exp_o    = exp_q;
    for (int i = 0; i < NLANE; i++) begin
      if (i < int'(n_q)) begin
        ore_d[i] = lre_d[i];
        oim_d[i] = lim_d[i];
      end
    end
`ifdef MRD_GATHER_PRESCALE_EN
    if (margin_nxt == 2'd0) begin
      for (int i = 0; i < NLANE; i++) begin
        ore_d[i] = half_round(ore_d[i]);
        oim_d[i] = half_round(oim_d[i]);
      end
      exp_o    = (exp_q == 4'hF) ? 4'hF : 4'(exp_q + 4'd1);
      margin_o = 2'd1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      k_q     <= 3'd0;
      n_q     <= RDX5;
      exp_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        k_q <= last ? 3'd0 : 3'(k_q + 3'd1);
        if (first) begin
          n_q   <= map_radix(bus.radix_sel);
          exp_q <= bus.exp_in;
        end
      end
    end
  end

  // NOTE: lane storage is not reset; lanes beyond N are masked and the rest are rewritten before use.
  always_ff @(posedge clk) begin
    lre_q <= lre_d;
    lim_q <= lim_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_val    <= 1'b0;
      bus.dout_real  <= '0;
      bus.dout_imag  <= '0;
      bus.radix_out  <= RDX5;
      bus.margin_out <= 2'd3;
      bus.exp_out    <= 4'd0;
    end else if (xfer) begin
      bus.out_val    <= 1'b1;
      bus.dout_real  <= ore_d;
      bus.dout_imag  <= oim_d;
      bus.radix_out  <= n_q;
      bus.margin_out <= margin_o;
      bus.exp_out    <= exp_o;
    end else if (bus.out_ready) begin
      bus.out_val    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mrd_rdx_gather.sv
// Directed self-checking bench for mrd_rdx_gather (default and prescale builds).
module tb_mrd_rdx_gather;
  import mrd_pkg::*;

  typedef logic [NLANE-1:0][WD-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mrd_rdx_gather_if bus ();

  mrd_rdx_gather dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t v5(int a, int b, int c, int d, int e);
    vec_t v;
    v[0] = WD'(a); v[1] = WD'(b); v[2] = WD'(c); v[3] = WD'(d); v[4] = WD'(e);
    return v;
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int re, int im);
    bus.in_val   = 1'b1;
    bus.din_real = WD'(re);
    bus.din_imag = WD'(im);
    tick();
  endtask

  task automatic check_vec(string tag, vec_t er, vec_t ei, int n, int m, int e);
    check({tag, ".val"},    128'(bus.out_val),    128'(1));
    check({tag, ".re"},     128'(bus.dout_real),  128'(er));
    check({tag, ".im"},     128'(bus.dout_imag),  128'(ei));
    check({tag, ".radix"},  128'(bus.radix_out),  128'(n));
    check({tag, ".margin"}, 128'(bus.margin_out), 128'(m));
    check({tag, ".exp"},    128'(bus.exp_out),    128'(e));
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_val    = 1'b0;
    bus.din_real  = '0;
    bus.din_imag  = '0;
    bus.radix_sel = 3'd5;
    bus.exp_in    = 4'd0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    check("rst.in_ready", 128'(bus.in_ready),   128'(1));
    check("rst.out_val",  128'(bus.out_val),    128'(0));
    check("rst.re",       128'(bus.dout_real),  128'(0));
    check("rst.im",       128'(bus.dout_imag),  128'(0));
    check("rst.radix",    128'(bus.radix_out),  128'(5));
    check("rst.margin",   128'(bus.margin_out), 128'(3));
    check("rst.exp",      128'(bus.exp_out),    128'(0));

    // Reset after 2 of 5 samples discards the partial vector
    drive(1, 1);
    drive(2, 2);
    rst = 1'b1; bus.in_val = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst.out_val",  128'(bus.out_val),  128'(0));
    check("midrst.in_ready", 128'(bus.in_ready), 128'(1));
    bus.exp_in = 4'd7;
    drive(11, -11);
    bus.exp_in = 4'd1;
    drive(12, -12);
    drive(13, -13);
    check("midrst.partial", 128'(bus.out_val), 128'(0));
    drive(14, -14);
    drive(15, -15);
    check_vec("midrst.vec", v5(11, 12, 13, 14, 15), v5(-11, -12, -13, -14, -15), 5, 3, 7);
    bus.in_val = 1'b0;
    tick();
    check("midrst.drop", 128'(bus.out_val), 128'(0));

    // N=3 with upper lanes zeroed
    bus.radix_sel = 3'd3; bus.exp_in = 4'd2;
    drive(100, -100);
    drive(200, 0);
    check("n3.early", 128'(bus.out_val), 128'(0));
    drive(-300, 50);
    check_vec("n3.vec", v5(100, 200, -300, 0, 0), v5(-100, 0, 50, 0, 0), 3, 3, 2);
    bus.in_val = 1'b0;
    tick();
    check("n3.drop", 128'(bus.out_val), 128'(0));

    // N=5 streaming at full rate
    bus.radix_sel = 3'd5; bus.exp_in = 4'd0;
    for (int j = 1; j <= 50; j++) begin
      drive(1000 + j - 1, -(1000 + j - 1));
      check("strm.in_ready", 128'(bus.in_ready), 128'(1));
      check("strm.out_val",  128'(bus.out_val),  128'((j % 5) == 0));
      if ((j % 5) == 0)
        check_vec("strm.vec",
                  v5(995 + j, 996 + j, 997 + j, 998 + j, 999 + j),
                  v5(-(995 + j), -(996 + j), -(997 + j), -(998 + j), -(999 + j)), 5, 3, 0);
    end
    bus.in_val = 1'b0;
    tick();
    check("strm.drop", 128'(bus.out_val), 128'(0));

    // Backpressure: out_ready low for 12 cycles with N=2
    bus.out_ready = 1'b0; bus.radix_sel = 3'd2; bus.exp_in = 4'd9;
    drive(10, 11);
    drive(12, 13);
    check_vec("bp.a", v5(10, 12, 0, 0, 0), v5(11, 13, 0, 0, 0), 2, 3, 9);
    bus.exp_in = 4'd4;
    drive(20, 21);
    drive(22, 23);
    for (int j = 0; j < 8; j++) begin
      check("bp.in_ready", 128'(bus.in_ready),  128'(0));
      check("bp.hold",     128'(bus.dout_real), 128'(v5(10, 12, 0, 0, 0)));
      drive(99, 99);
    end
    check_vec("bp.a_held", v5(10, 12, 0, 0, 0), v5(11, 13, 0, 0, 0), 2, 3, 9);
    bus.out_ready = 1'b1; bus.in_val = 1'b0;
    tick();
    check_vec("bp.b", v5(20, 22, 0, 0, 0), v5(21, 23, 0, 0, 0), 2, 3, 4);
    check("bp.in_ready_back", 128'(bus.in_ready), 128'(1));
    tick();
    check("bp.drop", 128'(bus.out_val), 128'(0));

    // Margin 0 at the positive extreme
    bus.radix_sel = 3'd4; bus.exp_in = 4'd5;
    drive(18'sh1FFFF, 0);
    drive(1, 1);
    drive(2, 2);
    drive(3, 3);
`ifdef MRD_GATHER_PRESCALE_EN
    check_vec("m0.vec", v5(65536, 1, 1, 2, 0), v5(0, 1, 1, 2, 0), 4, 1, 6);
`else
    check_vec("m0.vec", v5(131071, 1, 2, 3, 0), v5(0, 1, 2, 3, 0), 4, 0, 5);
`endif

    // Margin 2 at +-2^14, radix 7 maps to 4, radix_sel ignored for k>0
    bus.radix_sel = 3'd7; bus.exp_in = 4'd3;
    drive(16384, -16384);
    bus.radix_sel = 3'd2; bus.exp_in = 4'd8;
    drive(-16384, 16384);
    drive(16384, 16384);
    check("m2.early", 128'(bus.out_val), 128'(0));
    drive(-16384, -16384);
    check_vec("m2.vec", v5(16384, -16384, 16384, -16384, 0),
              v5(-16384, 16384, 16384, -16384, 0), 4, 2, 3);

    // Zero-margin vector at exponent 15
    bus.radix_sel = 3'd2; bus.exp_in = 4'd15;
    drive(18'sh1FFFF, 3);
    drive(3, -1);
`ifdef MRD_GATHER_PRESCALE_EN
    check_vec("ps.e15", v5(65536, 2, 0, 0, 0), v5(2, 0, 0, 0, 0), 2, 1, 15);
`else
    check_vec("ps.e15", v5(131071, 3, 0, 0, 0), v5(3, -1, 0, 0, 0), 2, 0, 15);
`endif

    // Negative extreme has headroom 0
    bus.exp_in = 4'd3;
    drive(-131072, 0);
    drive(5, 5);
`ifdef MRD_GATHER_PRESCALE_EN
    check_vec("ps.neg", v5(-65536, 3, 0, 0, 0), v5(0, 3, 0, 0, 0), 2, 1, 4);
`else
    check_vec("ps.neg", v5(-131072, 5, 0, 0, 0), v5(0, 5, 0, 0, 0), 2, 0, 3);
`endif
    bus.in_val = 1'b0;
    tick();
    check("end.drop", 128'(bus.out_val), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
